// File: rtl/adder_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : adder_pipe
//  Purpose  : Pipelined unsigned adder with optional running accumulation.
//             The sum is formed when a beat is accepted. The remaining stages
//             only carry the result, using valid/ready handshakes on both
//             sides. A stall on the output freezes the whole pipe.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module adder_pipe #(
  parameter int WIDTH     = 16,
  parameter int STAGES    = 2,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic                 i_mode,
  input  logic                 i_clear,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_overflow
);

  // Pipeline storage; index STAGES-1 drives the outputs.
  logic                 r_vld [STAGES];
  logic [ACC_WIDTH-1:0] r_sum [STAGES];
  logic                 r_ovf [STAGES];
  logic [ACC_WIDTH-1:0] r_acc;

  logic                 w_advance;
  logic                 w_accept;
  logic [ACC_WIDTH:0]   w_a_ext;
  logic [ACC_WIDTH:0]   w_b_ext;
  logic [ACC_WIDTH:0]   w_base;
  logic [ACC_WIDTH:0]   w_full;
  logic [ACC_WIDTH-1:0] w_plain;
  logic [ACC_WIDTH-1:0] w_result;
  logic                 w_ovf;

  // The pipe moves whenever the output slot is empty or is being drained.
  // Ready is forced low while rst is high so that no beat appears accepted
  // during reset.
  assign w_advance = !r_vld[STAGES-1] || i_ready;
  assign o_ready   = w_advance && !rst;
  assign w_accept  = i_valid && o_ready;

  // Operands are widened to ACC_WIDTH+1 bits so that the accumulate carry is
  // kept. The plain sum fits in ACC_WIDTH bits because ACC_WIDTH > WIDTH.
  assign w_a_ext  = {{(ACC_WIDTH+1-WIDTH){1'b0}}, i_a};
  assign w_b_ext  = {{(ACC_WIDTH+1-WIDTH){1'b0}}, i_b};
  assign w_base   = i_clear ? '0 : {1'b0, r_acc};
  assign w_full   = w_base + w_a_ext + w_b_ext;
  assign w_plain  = w_a_ext[ACC_WIDTH-1:0] + w_b_ext[ACC_WIDTH-1:0];
  assign w_result = i_mode ? w_full[ACC_WIDTH-1:0] : w_plain;
  assign w_ovf    = i_mode & w_full[ACC_WIDTH];

  // The accumulator changes only on an accepted accumulate beat. Add beats
  // and bubbles leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_accept && i_mode) begin
      r_acc <= w_full[ACC_WIDTH-1:0];
    end
  end

  // Shift register of results. Stage 0 loads the new beat, or a bubble when
  // no beat is accepted. Every stage holds while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_vld[i] <= 1'b0;
        r_sum[i] <= '0;
        r_ovf[i] <= 1'b0;
      end
    end else if (w_advance) begin
      r_vld[0] <= w_accept;
      r_sum[0] <= w_result;
      r_ovf[0] <= w_ovf;
      for (int i = 1; i < STAGES; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_sum[i] <= r_sum[i-1];
        r_ovf[i] <= r_ovf[i-1];
      end
    end
  end

  assign o_valid    = r_vld[STAGES-1];
  assign o_sum      = r_sum[STAGES-1];
  assign o_overflow = r_ovf[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_adder_pipe
//  Purpose  : Directed self-checking bench for adder_pipe. It checks the
//             default build and a narrow-accumulator build (ACC_WIDTH=17).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Default build (WIDTH=16, STAGES=2, ACC_WIDTH=32)
  logic        i_valid = 1'b0, i_mode = 1'b0, i_clear = 1'b0, i_ready = 1'b1;
  logic [15:0] i_a = '0, i_b = '0;
  logic        o_ready, o_valid, o_overflow;
  logic [31:0] o_sum;

  // Narrow accumulator build (ACC_WIDTH=17)
  logic        v17 = 1'b0, m17 = 1'b0, c17 = 1'b0, r17 = 1'b1;
  logic [15:0] a17 = '0, b17 = '0;
  logic        rdy17, ov17, ovf17;
  logic [16:0] sum17;

  int n_cmp = 0;
  int n_err = 0;

  adder_pipe u_dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_mode(i_mode), .i_clear(i_clear),
    .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_overflow(o_overflow)
  );

  adder_pipe #(.WIDTH(16), .STAGES(2), .ACC_WIDTH(17)) u_dut17 (
    .clk(clk), .rst(rst), .i_valid(v17), .o_ready(rdy17),
    .i_a(a17), .i_b(b17), .i_mode(m17), .i_clear(c17),
    .o_valid(ov17), .i_ready(r17), .o_sum(sum17), .o_overflow(ovf17)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic mode, input logic clr);
    i_valid = 1'b1; i_a = a; i_b = b; i_mode = mode; i_clear = clr;
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_sum",   {32'd0, o_sum},   64'd0);
    chk("rst_ovf",   {63'd0, o_overflow}, 64'd0);
    chk("rst_ready", {63'd0, o_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {63'd0, o_ready}, 64'd1);

    // ---------------- add with carry out of WIDTH ----------------
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    tick();
    i_valid = 1'b0;
    chk("carry_lat1_valid", {63'd0, o_valid}, 64'd0);
    tick();
    chk("carry_valid", {63'd0, o_valid}, 64'd1);
    chk("carry_sum",   {32'd0, o_sum},   64'h0001_0000);
    chk("carry_ovf",   {63'd0, o_overflow}, 64'd0);
    tick();
    chk("carry_drained", {63'd0, o_valid}, 64'd0);

    // ---------------- accumulate sequence, back-to-back ----------------
    drive(16'd5, 16'd7, 1'b1, 1'b1);  tick();
    drive(16'd1, 16'd2, 1'b1, 1'b0);  tick();
    chk("acc1_sum", {32'd0, o_sum}, 64'd12);
    chk("acc1_valid", {63'd0, o_valid}, 64'd1);
    drive(16'd3, 16'd4, 1'b0, 1'b1);  tick();
    chk("acc2_sum", {32'd0, o_sum}, 64'd15);
    drive(16'd0, 16'd0, 1'b1, 1'b0);  tick();
    i_valid = 1'b0;
    chk("acc_addbeat_sum", {32'd0, o_sum}, 64'd7);
    tick();
    chk("acc_after_add_sum", {32'd0, o_sum}, 64'd15);
    chk("acc_after_add_ovf", {63'd0, o_overflow}, 64'd0);
    tick();

    // ---------------- wrap on the 17-bit accumulator ----------------
    v17 = 1'b1; m17 = 1'b1; c17 = 1'b1; a17 = 16'hFFFF; b17 = 16'hFFFF;
    tick();
    c17 = 1'b0; a17 = 16'h0001; b17 = 16'h0001;
    tick();
    v17 = 1'b0;
    chk("wrap1_sum", {47'd0, sum17}, 64'h1FFFE);
    chk("wrap1_ovf", {63'd0, ovf17}, 64'd0);
    tick();
    chk("wrap2_valid", {63'd0, ov17}, 64'd1);
    chk("wrap2_sum", {47'd0, sum17}, 64'h0);
    chk("wrap2_ovf", {63'd0, ovf17}, 64'd1);
    tick();

    // ---------------- backpressure ----------------
    drive(16'd1, 16'd1, 1'b0, 1'b0); tick();
    drive(16'd2, 16'd2, 1'b0, 1'b0); tick();
    drive(16'd3, 16'd3, 1'b0, 1'b0);
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_ready", {63'd0, o_ready}, 64'd0);
      chk("stall_valid", {63'd0, o_valid}, 64'd1);
      chk("stall_sum",   {32'd0, o_sum},   64'd2);
      tick();
    end
    i_ready = 1'b1;
    #1;
    chk("unstall_ready", {63'd0, o_ready}, 64'd1);
    tick();
    i_valid = 1'b0;
    chk("bp_res2_valid", {63'd0, o_valid}, 64'd1);
    chk("bp_res2_sum",   {32'd0, o_sum},   64'd4);
    tick();
    chk("bp_res3_valid", {63'd0, o_valid}, 64'd1);
    chk("bp_res3_sum",   {32'd0, o_sum},   64'd6);
    tick();
    chk("bp_drained", {63'd0, o_valid}, 64'd0);

    // ---------------- throughput: 10 consecutive beats ----------------
    for (int k = 0; k < 10; k++) begin
      drive(16'(k), 16'(k), 1'b0, 1'b0);
      tick();
      if (k >= 1) begin
        chk("tput_valid", {63'd0, o_valid}, 64'd1);
        chk("tput_sum",   {32'd0, o_sum},   64'(2 * (k - 1)));
      end
    end
    i_valid = 1'b0;
    tick();
    chk("tput_last_valid", {63'd0, o_valid}, 64'd1);
    chk("tput_last_sum",   {32'd0, o_sum},   64'd18);
    tick();
    chk("tput_drained", {63'd0, o_valid}, 64'd0);

    // ---------------- reset mid-operation ----------------
    drive(16'd1, 16'd1, 1'b1, 1'b1); tick();
    drive(16'd2, 16'd2, 1'b1, 1'b0); tick();
    i_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_ready", {63'd0, o_ready}, 64'd0);
    tick();
    rst = 1'b0;
    chk("midrst_valid", {63'd0, o_valid}, 64'd0);
    chk("midrst_sum",   {32'd0, o_sum},   64'd0);
    tick();
    chk("midrst_no_stale", {63'd0, o_valid}, 64'd0);
    drive(16'd1, 16'd1, 1'b1, 1'b0); tick();
    i_valid = 1'b0;
    tick();
    chk("postrst_valid", {63'd0, o_valid}, 64'd1);
    chk("postrst_acc",   {32'd0, o_sum},   64'd2);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
